// File: rtl/fp16_sub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : fp16_sub_pipe_if
// Brief   : Input/output handshake bundle for the pipelined FP16 subtractor.
// Revision: 1.0
// ============================================================================
interface fp16_sub_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface
`default_nettype wire

// File: rtl/fp16_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fp16_sub_pipe
// Brief   : Three-stage truncating FP16 subtractor (a - b) with full backpressure.
// Revision: 1.0
// ============================================================================
module fp16_sub_pipe #(
    parameter int TAG_W  = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  wire            clk,
    input  wire            rst,
    fp16_sub_pipe_if.slave bus
);
    localparam logic [14:0] c_MAX_FIN = 15'h7BFF;
    localparam logic [14:0] c_INF     = 15'h7C00;

    logic             s1_v_q, s2_v_q, s3_v_q;
    logic             s1_adv, s2_adv, s3_adv;
    logic             s1_sa_q, s1_sb_q;
    logic [4:0]       s1_exp_q;
    logic [10:0]      s1_ma_q, s1_mb_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [11:0]      s2_mag_q;
    logic             s2_sign_q;
    logic [4:0]       s2_exp_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [15:0]      s3_res_q;
    logic [TAG_W-1:0] s3_tag_q;

    // Stall chain: each stage moves when empty or when its successor moves.
    assign s3_adv = !s3_v_q || bus.out_ready;
    assign s2_adv = !s2_v_q || s3_adv;
    assign s1_adv = !s1_v_q || s2_adv;

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s3_v_q;
    assign bus.out_result = s3_res_q;
    assign bus.out_tag    = s3_tag_q;
    assign bus.busy       = s1_v_q | s2_v_q | s3_v_q;

    function automatic logic [3:0] f_lead_zeros(input logic [10:0] m);
        logic [3:0] lz;
        lz = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (m[i]) lz = 4'(10 - i);
        end
        return lz;
    endfunction

    // Stage 1: unpack and align to the larger exponent
    logic [4:0]  w_ea, w_eb, w_shift;
    logic [10:0] w_ma, w_mb;
    logic [4:0]  s1_exp_d;
    logic [10:0] s1_ma_d, s1_mb_d;

    always_comb begin
        w_ea = bus.in_a[14:10];
        w_eb = bus.in_b[14:10];
        w_ma = {|w_ea, bus.in_a[9:0]};
        w_mb = {|w_eb, bus.in_b[9:0]};
        if (w_ea >= w_eb) begin
            w_shift  = w_ea - w_eb;
            s1_exp_d = w_ea;
            s1_ma_d  = w_ma;
            s1_mb_d  = w_mb >> w_shift;
        end else begin
            w_shift  = w_eb - w_ea;
            s1_exp_d = w_eb;
            s1_ma_d  = w_ma >> w_shift;
            s1_mb_d  = w_mb;
        end
    end

    // Stage 2: signed-magnitude add/subtract
    logic [11:0] s2_mag_d;
    logic        s2_sign_d;

    always_comb begin
        if (s1_sa_q == s1_sb_q) begin
            s2_mag_d  = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};
            s2_sign_d = s1_sa_q;
        end else if (s1_ma_q >= s1_mb_q) begin
            s2_mag_d  = {1'b0, s1_ma_q - s1_mb_q};
            s2_sign_d = s1_sa_q;
        end else begin
            s2_mag_d  = {1'b0, s1_mb_q - s1_ma_q};
            s2_sign_d = s1_sb_q;
        end
    end

    // Stage 3: normalise and pack; zero magnitude always packs as +0
    logic [3:0]  w_lz;
    logic [9:0]  w_frac;
    logic [5:0]  w_exp_inc;
    logic [15:0] s3_res_d;

    always_comb begin
        w_lz      = f_lead_zeros(s2_mag_q[10:0]);
        w_frac    = 10'(s2_mag_q[10:0] << w_lz);
        w_exp_inc = {1'b0, s2_exp_q} + 6'd1;
        s3_res_d  = 16'h0000;
        if (s2_mag_q == 12'd0) begin
            s3_res_d = 16'h0000;
        end else if (s2_mag_q[11]) begin
            if (w_exp_inc >= 6'd31)
                s3_res_d = {s2_sign_q, SAT_EN ? c_MAX_FIN : c_INF};
            else
                s3_res_d = {s2_sign_q, w_exp_inc[4:0], s2_mag_q[10:1]};
        end else if ({1'b0, w_lz} >= s2_exp_q) begin
            s3_res_d = 16'h0000;
        end else begin
            s3_res_d = {s2_sign_q, s2_exp_q - {1'b0, w_lz}, w_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_sa_q   <= 1'b0;
            s1_sb_q   <= 1'b0;
            s1_exp_q  <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s1_tag_q  <= '0;
            s2_mag_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_tag_q  <= '0;
            s3_res_q  <= '0;
            s3_tag_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_q   <= bus.in_valid;
                s1_sa_q  <= bus.in_a[15];
                s1_sb_q  <= ~bus.in_b[15];
                s1_exp_q <= s1_exp_d;
                s1_ma_q  <= s1_ma_d;
                s1_mb_q  <= s1_mb_d;
                s1_tag_q <= bus.in_tag;
            end
            if (s2_adv) begin
                s2_v_q    <= s1_v_q;
                s2_mag_q  <= s2_mag_d;
                s2_sign_q <= s2_sign_d;
                s2_exp_q  <= s1_exp_q;
                s2_tag_q  <= s1_tag_q;
            end
            if (s3_adv) begin
                s3_v_q <= s2_v_q;
                if (s2_v_q) begin
                    s3_res_q <= s3_res_d;
                    s3_tag_q <= s2_tag_q;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp16_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp16_sub_pipe
// Brief   : Self-checking bench for fp16_sub_pipe (saturating and Inf variants).
// Revision: 1.0
// ============================================================================
module tb_fp16_sub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp16_sub_pipe_if #(.TAG_W(4)) bus_s ();
    fp16_sub_pipe_if #(.TAG_W(4)) bus_i ();

    assign bus_i.in_valid  = bus_s.in_valid;
    assign bus_i.in_a      = bus_s.in_a;
    assign bus_i.in_b      = bus_s.in_b;
    assign bus_i.in_tag    = bus_s.in_tag;
    assign bus_i.out_ready = bus_s.out_ready;

    fp16_sub_pipe #(.TAG_W(4), .SAT_EN(1'b1)) dut_sat (.clk(clk), .rst(rst), .bus(bus_s));
    fp16_sub_pipe #(.TAG_W(4), .SAT_EN(1'b0)) dut_inf (.clk(clk), .rst(rst), .bus(bus_i));

    typedef struct {
        logic [15:0] rs;
        logic [15:0] ri;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [3:0]  qt[$];
    int          idx    = 0;
    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    bit          held_v = 1'b0;
    logic [15:0] held_res;
    logic [3:0]  held_tag;

    task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: plain signed-integer arithmetic on aligned significands
    function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input bit sat);
        int ea, eb, ma, mb, ec, r, mag, e, lz;
        logic s;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = int'(a[9:0]) + ((ea != 0) ? 1024 : 0);
        mb = int'(b[9:0]) + ((eb != 0) ? 1024 : 0);
        ec = (ea > eb) ? ea : eb;
        if (ea > eb) mb = (ea - eb >= 11) ? 0 : (mb >> (ea - eb));
        else         ma = (eb - ea >= 11) ? 0 : (ma >> (eb - ea));
        r = (a[15] ? -ma : ma) - (b[15] ? -mb : mb);
        if (r == 0) return 16'h0000;
        s   = (r < 0);
        mag = (r < 0) ? -r : r;
        if (mag >= 2048) begin
            mag = mag / 2;
            e   = ec + 1;
            if (e >= 31) return sat ? {s, 15'h7BFF} : {s, 5'd31, 10'd0};
        end else begin
            lz = 0;
            while (mag < 1024) begin
                mag = mag * 2;
                lz++;
            end
            if (lz >= ec) return 16'h0000;
            e = ec - lz;
        end
        return {s, 5'(e), 10'(mag % 1024)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            t_check("variant_valid", {31'd0, bus_i.out_valid}, {31'd0, bus_s.out_valid});
            if (held_v) begin
                t_check("hold_valid", {31'd0, bus_s.out_valid}, 32'd1);
                t_check("hold_result", {16'd0, bus_s.out_result}, {16'd0, held_res});
                t_check("hold_tag", {28'd0, bus_s.out_tag}, {28'd0, held_tag});
            end
            if (bus_s.out_valid && bus_s.out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    t_check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    t_check("res_sat", {16'd0, bus_s.out_result}, {16'd0, sb[0].rs});
                    t_check("res_inf", {16'd0, bus_i.out_result}, {16'd0, sb[0].ri});
                    t_check("tag", {28'd0, bus_s.out_tag}, {28'd0, sb[0].tag});
                    void'(sb.pop_front());
                end
            end
            held_v   = bus_s.out_valid && !bus_s.out_ready;
            held_res = bus_s.out_result;
            held_tag = bus_s.out_tag;
            if (bus_s.in_valid && bus_s.in_ready)
                sb.push_back('{rs: ref_sub(bus_s.in_a, bus_s.in_b, 1'b1),
                               ri: ref_sub(bus_s.in_a, bus_s.in_b, 1'b0),
                               tag: bus_s.in_tag});
        end
    end

    task automatic add_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        qa.push_back(a);
        qb.push_back(b);
        qt.push_back(t);
    endtask

    task automatic present();
        if (idx < qa.size()) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_a     = qa[idx];
            bus_s.in_b     = qb[idx];
            bus_s.in_tag   = qt[idx];
        end else begin
            bus_s.in_valid = 1'b0;
        end
    endtask

    // rand_ready: pick out_ready at random each cycle, else leave it alone
    task automatic drive_cycles(input int ncyc, input bit rand_ready);
        bit fire;
        for (int c = 0; c < ncyc; c++) begin
            present();
            if (rand_ready) bus_s.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = bus_s.in_valid && bus_s.in_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        present();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        bus_s.out_ready = 1'b1;
        while ((sb.size() != 0 || idx < qa.size()) && n < budget) begin
            drive_cycles(1, 1'b0);
            n++;
        end
        t_check("drain_sb_empty", sb.size(), 32'd0);
    endtask

    task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] t, input logic [15:0] exp_s, input logic [15:0] exp_i);
        int n;
        bus_s.out_ready = 1'b1;
        add_op(a, b, t);
        drive_cycles(1, 1'b0);
        n = 0;
        while (!bus_s.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        t_check({nm, "_latency"}, n, 32'd2);
        t_check({nm, "_sat"}, {16'd0, bus_s.out_result}, {16'd0, exp_s});
        t_check({nm, "_inf"}, {16'd0, bus_i.out_result}, {16'd0, exp_i});
        t_check({nm, "_tag"}, {28'd0, bus_s.out_tag}, {28'd0, t});
        drive_cycles(1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [15:0] a, b;
        bus_s.in_valid  = 1'b0;
        bus_s.in_a      = '0;
        bus_s.in_b      = '0;
        bus_s.in_tag    = '0;
        bus_s.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        t_check("rst_out_valid", {31'd0, bus_s.out_valid}, 32'd0);
        t_check("rst_out_result", {16'd0, bus_s.out_result}, 32'd0);
        t_check("rst_out_tag", {28'd0, bus_s.out_tag}, 32'd0);
        t_check("rst_busy", {31'd0, bus_s.busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        t_check("rst_in_ready", {31'd0, bus_s.in_ready}, 32'd1);

        directed("t1_3m1",  16'h4200, 16'h3C00, 4'h1, 16'h4000, 16'h4000);
        directed("t2_1m1",  16'h3C00, 16'h3C00, 4'h2, 16'h0000, 16'h0000);
        directed("t2_1mn1", 16'h3C00, 16'hBC00, 4'h3, 16'h4000, 16'h4000);
        directed("t3_half", 16'h3800, 16'h3C00, 4'h5, 16'hB800, 16'hB800);
        directed("t4_ovf",  16'h7BFF, 16'hFBFF, 4'h6, 16'h7BFF, 16'h7C00);
        directed("t4_novf", 16'hFBFF, 16'h7BFF, 4'h7, 16'hFBFF, 16'hFC00);
        directed("flush",   16'h0400, 16'h0200, 4'h8, 16'h0000, 16'h0000);
        directed("far_shift", 16'h6000, 16'h2C00, 4'h9, 16'h6000, 16'h6000);

        // Backpressure: five ops offered into a stalled pipe
        bus_s.out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            add_op(16'h4000 + 16'(k * 16'h0100), 16'h3C00 + 16'(k), 4'(k + 10));
        p0 = idx;
        drive_cycles(8, 1'b0);
        t_check("bp_accepted", idx - p0, 32'd3);
        t_check("bp_in_ready", {31'd0, bus_s.in_ready}, 32'd0);
        t_check("bp_busy", {31'd0, bus_s.busy}, 32'd1);
        p0 = pops;
        bus_s.out_ready = 1'b1;
        drive_cycles(5, 1'b0);
        t_check("bp_emerged", pops - p0, 32'd5);
        wait_drain(20);

        // Reset with three ops in flight
        bus_s.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) add_op(16'h5000 + 16'(k), 16'h3C00, 4'(k));
        drive_cycles(4, 1'b0);
        t_check("rst_fill_busy", {31'd0, bus_s.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t_check("midrst_out_valid", {31'd0, bus_s.out_valid}, 32'd0);
        t_check("midrst_busy", {31'd0, bus_s.busy}, 32'd0);
        bus_s.out_ready = 1'b1;
        p0 = pops;
        drive_cycles(6, 1'b0);
        t_check("midrst_no_ghost", pops - p0, 32'd0);

        // Random back-to-back stream with random out_ready
        for (int k = 0; k < 400; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
            add_op(a, b, 4'($urandom));
        end
        for (int c = 0; c < 5000 && idx < qa.size(); c++) drive_cycles(1, 1'b1);
        t_check("rand_all_sent", idx, qa.size());
        wait_drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
